// File: rtl/paddle_ctrl.sv
// paddle_ctrl
//   Turns four raw paddle push-buttons into the top-edge y coordinates of the
//   left and right paddles. Keys are synchronised and debounced. Movement
//   happens once per movement tick, is STEP pixels per tick, and is clamped
//   to [Y_MIN, Y_MAX]. After every point both paddles re-centre and stay
//   frozen for HOLD_TICKS movement ticks.
//
// Ports
//   vga_clk     in   pixel clock, the only clock
//   sys_rst_n   in   asynchronous active-low reset
//   start       in   game enable, low forces IDLE with centred paddles
//   guiwei      in   one-cycle pulse on each point scored
//   key_up0_n   in   left paddle up button, raw, active-low
//   key_dn0_n   in   left paddle down button, raw, active-low
//   key_up1_n   in   right paddle up button, raw, active-low
//   key_dn1_n   in   right paddle down button, raw, active-low
//   padbody_y0  out  left paddle top y
//   padbody_y1  out  right paddle top y
//   frozen      out  high while keys are ignored (IDLE or HOLD)
module paddle_ctrl #(
   parameter int V_DISP     = 480,
   parameter int SLDE_W     = 10,
   parameter int BODY_L     = 60,
   parameter int STEP       = 2,
   parameter int MOVE_DIV   = 200000,
   parameter int DEB_CNT    = 250000,
   parameter int HOLD_TICKS = 32
) (
   input  logic       vga_clk,
   input  logic       sys_rst_n,
   input  logic       start,
   input  logic       guiwei,
   input  logic       key_up0_n,
   input  logic       key_dn0_n,
   input  logic       key_up1_n,
   input  logic       key_dn1_n,
   output logic [9:0] padbody_y0,
   output logic [9:0] padbody_y1,
   output logic       frozen
);

   localparam int DEB_W  = (DEB_CNT    > 1) ? $clog2(DEB_CNT)      : 1;
   localparam int DIV_W  = (MOVE_DIV   > 1) ? $clog2(MOVE_DIV)     : 1;
   localparam int HOLD_W = $clog2(HOLD_TICKS + 1);

   localparam logic [10:0] Y_CTR  = 11'(V_DISP / 2 - BODY_L / 2);
   localparam logic [10:0] Y_MIN  = 11'(SLDE_W);
   localparam logic [10:0] Y_MAX  = 11'(V_DISP - SLDE_W - BODY_L);
   localparam logic [10:0] STEP_Y = 11'(STEP);

   localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CNT - 1);
   localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(MOVE_DIV - 1);
   localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_TICKS);
   localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HOLD = 2'd2
   } state_t;

   // One tick of movement for a paddle. Pressed means 0; both or neither
   // pressed leaves the position alone. Clamping is done before the subtract
   // so the 11-bit value never wraps.
   function automatic logic [10:0] move_y(input logic [10:0] y,
                                          input logic        up_n,
                                          input logic        dn_n);
      logic [10:0] r;
      r = y;
      if (!up_n && dn_n)
         r = (y >= Y_MIN + STEP_Y) ? y - STEP_Y : Y_MIN;
      else if (up_n && !dn_n)
         r = (y + STEP_Y <= Y_MAX) ? y + STEP_Y : Y_MAX;
      return r;
   endfunction

   // Key bit order: 0 up0, 1 dn0, 2 up1, 3 dn1
   logic [3:0]       key_raw;
   logic [3:0]       sync1, sync2, deb;
   logic [DEB_W-1:0] deb_cnt [4];

   logic [DIV_W-1:0]  div_cnt;
   logic              tick;

   state_t            state_q, state_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic [9:0]        y0_q, y0_d, y1_q, y1_d;
   logic              frozen_q;

   assign key_raw = {key_dn1_n, key_up1_n, key_dn0_n, key_up0_n};

   // Synchroniser and debounce: a change is accepted only after the synced
   // value has differed from the debounced value for DEB_CNT edges in a row.
   always_ff @(posedge vga_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         sync1 <= 4'hF;
         sync2 <= 4'hF;
         deb   <= 4'hF;
         for (int i = 0; i < 4; i++) deb_cnt[i] <= '0;
      end else begin
         sync1 <= key_raw;
         sync2 <= sync1;
         for (int i = 0; i < 4; i++) begin
            if (sync2[i] == deb[i]) begin
               deb_cnt[i] <= '0;
            end else if (deb_cnt[i] == DEB_LAST) begin
               deb[i]     <= sync2[i];
               deb_cnt[i] <= '0;
            end else begin
               deb_cnt[i] <= deb_cnt[i] + 1'b1;
            end
         end
      end
   end

   // Free-running movement tick divider, active in every state
   always_ff @(posedge vga_clk or negedge sys_rst_n) begin
      if (!sys_rst_n)
         div_cnt <= '0;
      else if (div_cnt == DIV_LAST)
         div_cnt <= '0;
      else
         div_cnt <= div_cnt + 1'b1;
   end

   assign tick = (div_cnt == DIV_LAST);

   always_ff @(posedge vga_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q  <= ST_IDLE;
         hold_q   <= '0;
         y0_q     <= Y_CTR[9:0];
         y1_q     <= Y_CTR[9:0];
         frozen_q <= 1'b1;
      end else begin
         state_q  <= state_d;
         hold_q   <= hold_d;
         y0_q     <= y0_d;
         y1_q     <= y1_d;
         frozen_q <= (state_d != ST_RUN);
      end
   end

   // A point (guiwei) wins over a coincident tick; start=0 wins over all.
   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      y0_d    = y0_q;
      y1_d    = y1_q;
      if (!start) begin
         state_d = ST_IDLE;
         hold_d  = '0;
         y0_d    = Y_CTR[9:0];
         y1_d    = Y_CTR[9:0];
      end else begin
         case (state_q)
            ST_IDLE: state_d = ST_RUN;
            ST_RUN: begin
               if (guiwei) begin
                  state_d = ST_HOLD;
                  hold_d  = HOLD_LOAD;
                  y0_d    = Y_CTR[9:0];
                  y1_d    = Y_CTR[9:0];
               end else if (tick) begin
                  y0_d = 10'(move_y({1'b0, y0_q}, deb[0], deb[1]));
                  y1_d = 10'(move_y({1'b0, y1_q}, deb[2], deb[3]));
               end
            end
            ST_HOLD: begin
               if (guiwei) begin
                  hold_d = HOLD_LOAD;
                  y0_d   = Y_CTR[9:0];
                  y1_d   = Y_CTR[9:0];
               end else if (tick) begin
                  if (hold_q == HOLD_ONE)
                     state_d = ST_RUN;
                  else
                     hold_d = hold_q - 1'b1;
               end
            end
            default: begin
               state_d = ST_IDLE;
               hold_d  = '0;
            end
         endcase
      end
   end

   assign padbody_y0 = y0_q;
   assign padbody_y1 = y1_q;
   assign frozen     = frozen_q;

endmodule

// File: tb/tb_paddle_ctrl.sv
// Bench for paddle_ctrl with small MOVE_DIV / DEB_CNT / HOLD_TICKS.
// A behavioural model predicts the outputs after every clock edge and pushes
// them into a scoreboard queue; a monitor on the falling edge pops and checks.
module tb_paddle_ctrl;

   localparam int V_DISP     = 480;
   localparam int SLDE_W     = 10;
   localparam int BODY_L     = 60;
   localparam int STEP       = 2;
   localparam int MOVE_DIV   = 4;
   localparam int DEB_CNT    = 8;
   localparam int HOLD_TICKS = 3;

   localparam int Y_CTR = V_DISP / 2 - BODY_L / 2;
   localparam int Y_MIN = SLDE_W;
   localparam int Y_MAX = V_DISP - SLDE_W - BODY_L;

   logic       vga_clk = 1'b0;
   logic       sys_rst_n;
   logic       start;
   logic       guiwei;
   logic       key_up0_n, key_dn0_n, key_up1_n, key_dn1_n;
   logic [9:0] padbody_y0, padbody_y1;
   logic       frozen;

   paddle_ctrl #(
      .V_DISP(V_DISP), .SLDE_W(SLDE_W), .BODY_L(BODY_L), .STEP(STEP),
      .MOVE_DIV(MOVE_DIV), .DEB_CNT(DEB_CNT), .HOLD_TICKS(HOLD_TICKS)
   ) dut (
      .vga_clk(vga_clk), .sys_rst_n(sys_rst_n), .start(start), .guiwei(guiwei),
      .key_up0_n(key_up0_n), .key_dn0_n(key_dn0_n),
      .key_up1_n(key_up1_n), .key_dn1_n(key_dn1_n),
      .padbody_y0(padbody_y0), .padbody_y1(padbody_y1), .frozen(frozen)
   );

   always #5 vga_clk = ~vga_clk;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   logic [20:0] sb[$];

   // ---------------- behavioural reference model ----------------
   // m_mode: 0 idle, 1 run, 2 hold. Keys: 0 up0, 1 dn0, 2 up1, 3 dn1.
   int m_y0, m_y1, m_mode, m_hold, m_frz, m_k;
   bit m_s1[4], m_s2[4], m_deb[4];
   int m_run[4];

   function automatic int mv(int y, bit up_n, bit dn_n);
      if (!up_n && dn_n)  return (y - STEP < Y_MIN) ? Y_MIN : y - STEP;
      if (up_n && !dn_n)  return (y + STEP > Y_MAX) ? Y_MAX : y + STEP;
      return y;
   endfunction

   function automatic logic [20:0] m_out();
      return {10'(m_y0), 10'(m_y1), 1'(m_frz)};
   endfunction

   function automatic void model_reset();
      m_y0 = Y_CTR; m_y1 = Y_CTR; m_mode = 0; m_hold = 0; m_frz = 1; m_k = 0;
      for (int i = 0; i < 4; i++) begin
         m_s1[i] = 1; m_s2[i] = 1; m_deb[i] = 1; m_run[i] = 0;
      end
   endfunction

   // Predict the state right after the coming clock edge from current inputs.
   function automatic void model_edge();
      bit raw[4];
      bit is_tick;
      if (!sys_rst_n) begin
         model_reset();
         sb.push_back(m_out());
         return;
      end
      raw[0] = key_up0_n; raw[1] = key_dn0_n; raw[2] = key_up1_n; raw[3] = key_dn1_n;
      is_tick = ((m_k % MOVE_DIV) == MOVE_DIV - 1);
      if (!start) begin
         m_mode = 0; m_hold = 0; m_y0 = Y_CTR; m_y1 = Y_CTR;
      end else if (m_mode == 0) begin
         m_mode = 1;
      end else if (m_mode == 1) begin
         if (guiwei) begin
            m_mode = 2; m_hold = HOLD_TICKS; m_y0 = Y_CTR; m_y1 = Y_CTR;
         end else if (is_tick) begin
            m_y0 = mv(m_y0, m_deb[0], m_deb[1]);
            m_y1 = mv(m_y1, m_deb[2], m_deb[3]);
         end
      end else begin
         if (guiwei) begin
            m_hold = HOLD_TICKS; m_y0 = Y_CTR; m_y1 = Y_CTR;
         end else if (is_tick) begin
            if (m_hold == 1) m_mode = 1;
            else m_hold--;
         end
      end
      m_frz = (m_mode != 1);
      for (int i = 0; i < 4; i++) begin
         if (m_s2[i] != m_deb[i]) begin
            m_run[i]++;
            if (m_run[i] == DEB_CNT) begin
               m_deb[i] = m_s2[i];
               m_run[i] = 0;
            end
         end else begin
            m_run[i] = 0;
         end
         m_s2[i] = m_s1[i];
         m_s1[i] = raw[i];
      end
      m_k++;
      sb.push_back(m_out());
   endfunction

   // ---------------- monitor ----------------
   initial begin
      logic [20:0] e, got;
      forever begin
         @(negedge vga_clk);
         cyc++;
         if (sb.size() > 0) begin
            e   = sb.pop_front();
            got = {padbody_y0, padbody_y1, frozen};
            checks++;
            if (got !== e) begin
               failures++;
               $display("FAIL outputs cyc=%0d got y0=%0d y1=%0d frozen=%0b expected y0=%0d y1=%0d frozen=%0b",
                        cyc, got[20:11], got[10:1], got[0], e[20:11], e[10:1], e[0]);
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic step(int n = 1);
      for (int i = 0; i < n; i++) begin
         model_edge();
         @(posedge vga_clk);
         #1;
      end
   endtask

   // Reset lands between edges; the pending expectation becomes reset values.
   task automatic async_reset();
      #1;
      sys_rst_n = 1'b0;
      model_reset();
      if (sb.size() > 0) void'(sb.pop_back());
      sb.push_back(m_out());
   endtask

   task automatic release_keys();
      key_up0_n = 1; key_dn0_n = 1; key_up1_n = 1; key_dn1_n = 1;
   endtask

   initial begin
      sys_rst_n = 1'b0;
      start     = 1'b0;
      guiwei    = 1'b0;
      release_keys();
      model_reset();
      step(3);

      // left paddle driven up into the top clamp
      sys_rst_n = 1'b1;
      start     = 1'b1;
      key_up0_n = 1'b0;
      step(480);

      // right paddle driven down into the bottom clamp
      key_up0_n = 1'b1;
      key_dn1_n = 1'b0;
      step(450);
      key_dn1_n = 1'b1;
      step(20);

      // short glitch ignored, long press accepted
      key_dn0_n = 1'b0; step(5);
      key_dn0_n = 1'b1; step(30);
      key_dn0_n = 1'b0; step(20);
      key_dn0_n = 1'b1; step(30);

      // point scored exactly on a tick while a key is held
      key_dn0_n = 1'b0;
      step(40);
      while ((m_k % MOVE_DIV) != MOVE_DIV - 1) step();
      guiwei = 1'b1; step();
      guiwei = 1'b0; step(40);

      // point, then start dropped during HOLD, then both keys pressed
      guiwei = 1'b1; step();
      guiwei = 1'b0; step(3);
      start  = 1'b0; step(3);
      start  = 1'b1; step(2);
      key_up0_n = 1'b0; key_dn0_n = 1'b0;
      step(60);

      // reset mid-move, between edges
      release_keys();
      key_up1_n = 1'b0;
      step(40);
      async_reset();
      step(3);
      sys_rst_n = 1'b1;
      step(30);

      // random play
      for (int n = 0; n < 4000; n++) begin
         if ($urandom_range(0, 15) == 0) key_up0_n = ~key_up0_n;
         if ($urandom_range(0, 15) == 0) key_dn0_n = ~key_dn0_n;
         if ($urandom_range(0, 15) == 0) key_up1_n = ~key_up1_n;
         if ($urandom_range(0, 15) == 0) key_dn1_n = ~key_dn1_n;
         if ($urandom_range(0, 299) == 0) start = ~start;
         if (!start && $urandom_range(0, 7) == 0) start = 1'b1;
         guiwei = ($urandom_range(0, 59) == 0);
         step();
      end
      guiwei = 1'b0;

      for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge vga_clk);
      #1;
      if (sb.size() > 0) begin
         checks++;
         failures++;
         $display("FAIL drain pending=%0d required=0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
